inst_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the ARMv7 sample core. It holds the PC and IR and drives a synchronous instruction memory. It evaluates the IR condition field against externally supplied NZCV flags and resolves B-type branches. Fetch runs either manually (single-step Write_PC/Write_IR strobes from the board switches) or autonomously through a fetch FSM. It sits between the board wrapper and the instruction ROM and feeds Inst_condition/Inst_left to the display and decode logic.

---
 rtl/inst_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC/IR holding, ARM condition evaluation, B-type branch resolution,
// manual single-step strobes or an autonomous ADDR/LATCH/EXEC fetch loop.
//
// state | meaning
// IDLE  | waiting; manual Write_PC/Write_IR strobes honoured
// ADDR  | PC presented to memory, waiting one cycle for read data
// LATCH | imem_rdata captured into IR
// EXEC  | PC advanced from the freshly loaded IR
module inst_fetch_unit #(
    parameter int ADDR_W     = 6,
    parameter int RESET_ADDR = 0,
    parameter int CNT_W      = 16,
    parameter int BRANCH_EN  = 1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              Write_PC,
    input  logic              Write_IR,
    input  logic              Auto_Run,
    input  logic [3:0]        NZCV,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [3:0]        Inst_condition,
    output logic [27:0]       Inst_left,
    output logic [ADDR_W-1:0] Inst_Addr,
    output logic              flag,
    output logic              branch_taken,
    output logic              busy,
    output logic [CNT_W-1:0]  Inst_Count
);

    localparam int PW = ADDR_W + 2;
    localparam logic [PW-1:0] PC_RST = {ADDR_W'(RESET_ADDR), 2'b00};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_EXEC  = 2'd3;

    logic [PW-1:0]     pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        state_q, state_d;

    logic n_f, z_f, c_f, v_f;
    logic cond_ok;
    logic load_ir, upd_pc;
    logic signed [31:0] br_off32;
    logic [PW-1:0]      br_target;
    logic [PW-1:0]      next_pc;

    assign {n_f, z_f, c_f, v_f} = NZCV;

    always_comb begin
        cond_ok = 1'b0;
        case (ir_q[31:28])
            4'h0: cond_ok = z_f;
            4'h1: cond_ok = !z_f;
            4'h2: cond_ok = c_f;
            4'h3: cond_ok = !c_f;
            4'h4: cond_ok = n_f;
            4'h5: cond_ok = !n_f;
            4'h6: cond_ok = v_f;
            4'h7: cond_ok = !v_f;
            4'h8: cond_ok = c_f && !z_f;
            4'h9: cond_ok = !c_f || z_f;
            4'hA: cond_ok = (n_f == v_f);
            4'hB: cond_ok = (n_f != v_f);
            4'hC: cond_ok = !z_f && (n_f == v_f);
            4'hD: cond_ok = z_f || (n_f != v_f);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign flag         = cond_ok;
    assign branch_taken = (BRANCH_EN != 0) && (ir_q[27:25] == 3'b101) && cond_ok;

    // Branch target is relative to the IR's own address plus the 8-byte pipeline offset.
    assign br_off32  = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
    assign br_target = {ir_pc_q, 2'b00} + PW'(8) + PW'(br_off32);
    assign next_pc   = branch_taken ? br_target : pc_q + PW'(4);

    always_comb begin
        state_d = state_q;
        load_ir = 1'b0;
        upd_pc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Auto_Run) begin
                    state_d = S_ADDR;
                end else begin
                    load_ir = Write_IR;
                    upd_pc  = Write_PC;
                end
            end
            S_ADDR:  state_d = S_LATCH;
            S_LATCH: begin
                load_ir = 1'b1;
                state_d = S_EXEC;
            end
            default: begin
                upd_pc  = 1'b1;
                state_d = Auto_Run ? S_ADDR : S_IDLE;
            end
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        cnt_d   = cnt_q;
        if (load_ir) begin
            ir_d    = imem_rdata;
            ir_pc_d = pc_q[PW-1:2];
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (upd_pc) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            pc_q    <= PC_RST;
            ir_q    <= 32'h0;
            ir_pc_q <= ADDR_W'(RESET_ADDR);
            cnt_q   <= '0;
            state_q <= S_IDLE;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign imem_addr      = pc_q[PW-1:2];
    assign Inst_condition = ir_q[31:28];
    assign Inst_left      = ir_q[27:0];
    assign Inst_Addr      = ir_pc_q;
    assign busy           = (state_q != S_IDLE);
    assign Inst_Count     = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: default build, a BRANCH_EN=0 build and a RESET_ADDR=63 build
// share one stimulus stream, each with its own registered instruction ROM.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        Rst, Write_PC, Write_IR, Auto_Run;
    logic [3:0]  NZCV;
    logic        ovr_en;
    logic [31:0] ovr_word;

    logic [5:0]  a0, anb, aw;
    logic [31:0] d0, dnb, dw;
    logic [3:0]  cond0, condnb, condw;
    logic [27:0] left0, leftnb, leftw;
    logic [5:0]  ia0, ianb, iaw;
    logic        fl0, flnb, flw, bt0, btnb, btw, by0, bynb, byw;
    logic [15:0] ic0, icnb, icw;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [5:0] a);
        case (a)
            6'd0:    rom = 32'hE0801002;
            6'd1:    rom = 32'hE1A00000;
            6'd2:    rom = 32'h0AFFFFFD;
            default: rom = 32'hE3A00000 | {26'd0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        d0  <= ovr_en ? ovr_word : rom(a0);
        dnb <= ovr_en ? ovr_word : rom(anb);
        dw  <= ovr_en ? ovr_word : rom(aw);
    end

    inst_fetch_unit u_dut (
        .clk(clk), .Rst(Rst), .Write_PC(Write_PC), .Write_IR(Write_IR), .Auto_Run(Auto_Run),
        .NZCV(NZCV), .imem_addr(a0), .imem_rdata(d0), .Inst_condition(cond0), .Inst_left(left0),
        .Inst_Addr(ia0), .flag(fl0), .branch_taken(bt0), .busy(by0), .Inst_Count(ic0));

    inst_fetch_unit #(.BRANCH_EN(0)) u_dut_nb (
        .clk(clk), .Rst(Rst), .Write_PC(Write_PC), .Write_IR(Write_IR), .Auto_Run(Auto_Run),
        .NZCV(NZCV), .imem_addr(anb), .imem_rdata(dnb), .Inst_condition(condnb), .Inst_left(leftnb),
        .Inst_Addr(ianb), .flag(flnb), .branch_taken(btnb), .busy(bynb), .Inst_Count(icnb));

    inst_fetch_unit #(.RESET_ADDR(63)) u_dut_w (
        .clk(clk), .Rst(Rst), .Write_PC(Write_PC), .Write_IR(Write_IR), .Auto_Run(Auto_Run),
        .NZCV(NZCV), .imem_addr(aw), .imem_rdata(dw), .Inst_condition(condw), .Inst_left(leftw),
        .Inst_Addr(iaw), .flag(flw), .branch_taken(btw), .busy(byw), .Inst_Count(icw));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Auto_Run = 1'b0; Write_PC = 1'b0; Write_IR = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
    endtask

    task automatic pulse_ir();
        Write_IR = 1'b1; tick(); Write_IR = 1'b0;
    endtask

    task automatic pulse_pc();
        Write_PC = 1'b1; tick(); Write_PC = 1'b0;
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy & !z;
            4'h9: return !cy | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Auto run from word 0 through the BEQ at word 2, dropping Auto_Run before its EXEC edge.
    task automatic run_branch(input logic [3:0] f, input logic [5:0] exp0, input logic [5:0] expnb);
        do_reset();
        NZCV = f;
        Auto_Run = 1'b1;
        tick();
        chk("busy_rise", {31'd0, by0}, 32'd1);
        tick(); tick(); tick();
        chk("wrap_addr", {26'd0, aw}, 32'd0);
        chk("wrap_inst_addr", {26'd0, iaw}, 32'd63);
        chk("wrap_count", {16'd0, icw}, 32'd1);
        chk("auto_w0_pc", {26'd0, a0}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("br_inst_addr", {26'd0, ia0}, 32'd2);
        chk("br_taken", {31'd0, bt0}, {31'd0, f[2]});
        chk("br_taken_nb", {31'd0, btnb}, 32'd0);
        Auto_Run = 1'b0;
        tick();
        chk("br_pc", {26'd0, a0}, {26'd0, exp0});
        chk("br_pc_nb", {26'd0, anb}, {26'd0, expnb});
        chk("br_idle", {31'd0, by0}, 32'd0);
        chk("br_count", {16'd0, ic0}, 32'd3);
    endtask

    initial begin
        ovr_en = 1'b0; ovr_word = 32'h0; NZCV = 4'b0100;
        do_reset();
        chk("rst_pc", {26'd0, a0}, 32'd0);
        chk("rst_cond", {28'd0, cond0}, 32'd0);
        chk("rst_left", {4'd0, left0}, 32'd0);
        chk("rst_count", {16'd0, ic0}, 32'd0);
        chk("rst_busy", {31'd0, by0}, 32'd0);
        chk("rst_flag_z1", {31'd0, fl0}, 32'd1);
        chk("rst_w_pc", {26'd0, aw}, 32'd63);
        chk("rst_w_ia", {26'd0, iaw}, 32'd63);
        NZCV = 4'b0000; #1;
        chk("rst_flag_z0", {31'd0, fl0}, 32'd0);

        // Manual single step of word 0
        NZCV = 4'b0100;
        pulse_ir();
        chk("man_ir", {cond0, left0}, 32'hE0801002);
        chk("man_pc_held", {26'd0, a0}, 32'd0);
        pulse_pc();
        chk("man_cond", {28'd0, cond0}, 32'hE);
        chk("man_flag", {31'd0, fl0}, 32'd1);
        chk("man_bt", {31'd0, bt0}, 32'd0);
        chk("man_pc", {26'd0, a0}, 32'd1);
        chk("man_count", {16'd0, ic0}, 32'd1);
        chk("man_ia", {26'd0, ia0}, 32'd0);

        // Condition sweep via directly supplied memory words
        ovr_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            ovr_word = {c[3:0], 28'h1A00000};
            tick();
            pulse_ir();
            for (int f = 0; f < 16; f++) begin
                NZCV = f[3:0]; #1;
                chk($sformatf("cond_%0h_nzcv_%0h", c, f), {31'd0, fl0}, {31'd0, cond_ref(c[3:0], f[3:0])});
            end
        end
        chk("sweep_count", {16'd0, ic0}, 32'd17);

        // Manual branch: BEQ -3 held at word 1, target 4+8-12 = 0
        ovr_word = 32'h0AFFFFFD;
        tick();
        pulse_ir();
        NZCV = 4'b0100; #1;
        chk("man_br_bt", {31'd0, bt0}, 32'd1);
        chk("man_br_bt_nb", {31'd0, btnb}, 32'd0);
        pulse_pc();
        chk("man_br_pc", {26'd0, a0}, 32'd0);
        chk("man_br_pc_nb", {26'd0, anb}, 32'd2);
        NZCV = 4'b0000; #1;
        chk("man_br_nt", {31'd0, bt0}, 32'd0);
        ovr_en = 1'b0;

        run_branch(4'b0100, 6'd1, 6'd3);
        run_branch(4'b0000, 6'd3, 6'd3);

        // Auto_Run dropped while in LATCH
        do_reset();
        Auto_Run = 1'b1;
        tick(); tick();
        Auto_Run = 1'b0;
        tick();
        chk("mid_exec_busy", {31'd0, by0}, 32'd1);
        chk("mid_count", {16'd0, ic0}, 32'd1);
        tick();
        chk("mid_idle", {31'd0, by0}, 32'd0);
        chk("mid_pc", {26'd0, a0}, 32'd1);
        Write_IR = 1'b0;
        pulse_pc();
        chk("mid_man_pc", {26'd0, a0}, 32'd2);

        // Rst while in EXEC
        do_reset();
        Auto_Run = 1'b1;
        tick(); tick(); tick();
        chk("exec_count", {16'd0, ic0}, 32'd1);
        chk("exec_cond", {28'd0, cond0}, 32'hE);
        Rst = 1'b1;
        tick();
        chk("exrst_pc", {26'd0, a0}, 32'd0);
        chk("exrst_ir", {cond0, left0}, 32'd0);
        chk("exrst_count", {16'd0, ic0}, 32'd0);
        chk("exrst_busy", {31'd0, by0}, 32'd0);
        Rst = 1'b0; Auto_Run = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
